mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_MAX, 4, maximum consecutive DMA transfer cycles before one forced CPU cycle; legal range 1..15.
REQ-002 Parameter IO_WAIT, 2, port-access wait cycles during which the CPU is stalled; legal range 1..7.
REQ-003 clock  in  1  single system clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_address  in  20  core bus address; bits [15:0] are the port number when cpu_pr/cpu_pw is high.
REQ-006 cpu_out  in  8  core write data.
REQ-007 cpu_we / cpu_pr / cpu_pw  in  1 each  core memory write, port read and port write strobes.
REQ-008 cpu_in  out  8  read data to core; io_rdata during a port access, else mem_rdata.
REQ-009 cpu_ce  out  1  core clock enable; 0 stalls the core.
REQ-010 dma_req  in  1  DMA transfer request, held until acknowledged.
REQ-011 dma_address  in  20; dma_wdata  in  8; dma_we  in  1: DMA transfer descriptor.
REQ-012 dma_ack  out  1  high for exactly the cycles in which the DMA transfer executes.
REQ-013 dma_rdata  out  8  equals mem_rdata while dma_ack is high.
REQ-014 mem_address  out  20; mem_wdata  out  8; mem_we  out  1: memory bus; memory read is asynchronous.
REQ-015 mem_rdata  in  8  memory read data, valid in the same cycle as mem_address.
REQ-016 io_address  out  16; io_wdata  out  8; io_rd  out  1; io_wr  out  1; io_rdata  in  8: port bus.

Function
REQ-017 FSM states SHALL be CPU, DMA, IOWAIT; bus owner is the DMA requester in DMA, the core otherwise.
REQ-018 In CPU, a cpu_pr or cpu_pw strobe SHALL take priority over dma_req and move to IOWAIT with wait counter = IO_WAIT.
REQ-019 In CPU, with no port strobe and dma_req=1, the FSM SHALL move to DMA with cpu_ce=0 in that cycle.
REQ-020 In CPU, with no strobe and no request, cpu_ce SHALL be 1 and the memory bus SHALL carry cpu_address/cpu_out/cpu_we.
REQ-021 In DMA, each cycle SHALL execute one transfer: the memory bus carries the dma_* fields, dma_ack=1, cpu_ce=0, mem_we=dma_we.
REQ-022 The burst counter SHALL increment per DMA cycle; when it reaches BURST_MAX-1 or dma_req falls, the FSM SHALL return to CPU.
REQ-023 Following a burst limit, the next CPU-state cycle SHALL grant the core (cpu_ce=1) even if dma_req remains high.
REQ-024 In IOWAIT, io_address=cpu_address[15:0], io_wdata=cpu_out, io_rd=cpu_pr and io_wr=cpu_pw SHALL be held steady, and mem_we=0.
REQ-025 In IOWAIT, cpu_ce SHALL be 0 while the counter is nonzero; the counter decrements each cycle.
REQ-026 At counter 0, cpu_ce SHALL be 1, cpu_in SHALL be io_rdata, and the next state SHALL be CPU.
REQ-027 IOWAIT SHALL NOT be preempted by dma_req; a pending request is served on the first CPU cycle after it.
REQ-028 io_rd/io_wr SHALL be 0 outside IOWAIT; dma_ack SHALL be 0 outside DMA.

Reset
REQ-029 While reset=1: state=CPU, both counters=0, and cpu_ce, dma_ack, mem_we, io_rd and io_wr SHALL be 0.
REQ-030 Reset asserted mid-burst or mid-IOWAIT SHALL abort the access; the first cycle after release SHALL be CPU with no pending forced slot.

Configuration
REQ-031 Macro MEM_ARBITER_IO_WAIT_EN defined: IOWAIT state and IO_WAIT stall apply as above.
REQ-032 Macro MEM_ARBITER_IO_WAIT_EN undefined: there SHALL be no IOWAIT state; a port strobe in CPU completes in that cycle with cpu_ce=1, io_rd/io_wr driven combinationally, and cpu_in=io_rdata; IO_WAIT is ignored.

Structure
REQ-033 Package mem_arbiter_pkg SHALL hold the state encoding and the default BURST_MAX/IO_WAIT constants.
REQ-034 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-035 Idle core, cpu_address=20'h12345, mem_rdata=8'hA5 -> cpu_ce=1, mem_address=20'h12345, cpu_in=8'hA5.
REQ-036 dma_req held high for 10 cycles, BURST_MAX=4 -> ack pattern 4 DMA, 1 CPU, 4 DMA, 1 CPU; cpu_ce=1 only in the CPU cycles.
REQ-037 cpu_pr=1, cpu_address=20'h003F8, io_rdata=8'h5C, IO_WAIT=2 -> cpu_ce 0,0,1; io_rd=1 for 3 cycles; cpu_in=8'h5C on the third.
REQ-038 cpu_pw and dma_req rise together -> IOWAIT first; dma_ack=0 until the cycle after cpu_ce returns 1.
REQ-039 dma_we=1, dma_address=20'hB8000, dma_wdata=8'h41 -> mem_we=1 with that address and data, dma_ack=1, cpu_ce=0.
REQ-040 Reset pulsed on the 2nd cycle of a DMA burst -> dma_ack=0 and cpu_ce=0 during reset; CPU state after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the CPU / DMA / port-access memory arbiter.
//   - arb_state_t   : arbiter FSM state encoding
//   - BURST_MAX_DEF : default maximum DMA burst length before a forced CPU cycle
//   - IO_WAIT_DEF   : default number of core stall cycles for a port access
//   - BURST_W/WAIT_W: widths of the burst and port-wait counters
// Build option: MEM_ARBITER_IO_WAIT_EN adds the IOWAIT state (stalled port accesses).
package mem_arbiter_pkg;

    localparam int BURST_MAX_DEF = 4;
    localparam int IO_WAIT_DEF   = 2;
    localparam int BURST_W       = 4;   // holds 0..14 (BURST_MAX-1 with BURST_MAX <= 15)
    localparam int WAIT_W        = 3;   // holds 0..7

`ifdef MEM_ARBITER_IO_WAIT_EN
    typedef enum logic [1:0] {
        ST_CPU    = 2'd0,
        ST_DMA    = 2'd1,
        ST_IOWAIT = 2'd2
    } arb_state_t;
`else
    typedef enum logic [1:0] {
        ST_CPU = 2'd0,
        ST_DMA = 2'd1
    } arb_state_t;
`endif

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one asynchronous-read memory bus between a core and a DMA
// requester, and handles core port (I/O) accesses.
//
// State table
//   state  | meaning
//   CPU    | core owns the memory bus; grants DMA or starts a port access
//   DMA    | one DMA transfer per cycle, core stalled; bursts capped at BURST_MAX
//   IOWAIT | port access in progress, core stalled for IO_WAIT cycles
//            (only with MEM_ARBITER_IO_WAIT_EN defined)
//
// Ports
//   clock, reset (sync, active high)
//   cpu_address/cpu_out/cpu_we/cpu_pr/cpu_pw : core bus request
//   cpu_in, cpu_ce                           : read data and clock enable to core
//   dma_req/dma_address/dma_wdata/dma_we     : DMA transfer descriptor
//   dma_ack, dma_rdata                       : DMA transfer strobe and read data
//   mem_address/mem_wdata/mem_we, mem_rdata  : memory bus
//   io_address/io_wdata/io_rd/io_wr, io_rdata: port bus
//
// Build option MEM_ARBITER_IO_WAIT_EN: when defined, port accesses stall the core
// in IOWAIT; when undefined, a port access completes in a single CPU cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int IO_WAIT   = IO_WAIT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    input  logic        cpu_pr,
    input  logic        cpu_pw,
    output logic [7:0]  cpu_in,
    output logic        cpu_ce,
    input  logic        dma_req,
    input  logic [19:0] dma_address,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_we,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [19:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] io_address,
    output logic [7:0]  io_wdata,
    output logic        io_rd,
    output logic        io_wr,
    input  logic [7:0]  io_rdata
);

    if (BURST_MAX < 1 || BURST_MAX > 15 || IO_WAIT < 1 || IO_WAIT > 7) begin : g_bad_param
        $error("mem_arbiter: BURST_MAX must be 1..15 and IO_WAIT 1..7");
    end

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);
    localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);

    arb_state_t         state, state_nxt;
    logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
    // Set when a burst hit its length limit: the next CPU cycle belongs to the core.
    logic               forced, forced_nxt;
    logic               strobe;

    assign strobe = cpu_pr | cpu_pw;

`ifdef MEM_ARBITER_IO_WAIT_EN
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(IO_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    // Port access captured on entry so the port bus stays steady for the whole wait.
    logic [15:0]       io_address_q;
    logic [7:0]        io_wdata_q;
    logic              io_rd_q, io_wr_q;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_CPU;
            burst_cnt <= '0;
            forced    <= 1'b0;
`ifdef MEM_ARBITER_IO_WAIT_EN
            wait_cnt     <= '0;
            io_address_q <= '0;
            io_wdata_q   <= '0;
            io_rd_q      <= 1'b0;
            io_wr_q      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            forced    <= forced_nxt;
`ifdef MEM_ARBITER_IO_WAIT_EN
            wait_cnt <= wait_cnt_nxt;
            if (state == ST_CPU && strobe) begin
                io_address_q <= cpu_address[15:0];
                io_wdata_q   <= cpu_out;
                io_rd_q      <= cpu_pr;
                io_wr_q      <= cpu_pw;
            end
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        forced_nxt    = forced;
`ifdef MEM_ARBITER_IO_WAIT_EN
        wait_cnt_nxt  = wait_cnt;
`endif
        unique case (state)
            ST_CPU: begin
                burst_cnt_nxt = '0;
                if (strobe) begin
                    // A port access gives the core its cycle, so any owed slot is consumed.
                    forced_nxt = 1'b0;
`ifdef MEM_ARBITER_IO_WAIT_EN
                    state_nxt    = ST_IOWAIT;
                    wait_cnt_nxt = WAIT_INIT;
`endif
                end else if (forced) begin
                    // Core runs this cycle; DMA may resume right after it.
                    forced_nxt = 1'b0;
                    if (dma_req) state_nxt = ST_DMA;
                end else if (dma_req) begin
                    state_nxt = ST_DMA;
                end
            end
            ST_DMA: begin
                if (!dma_req) begin
                    state_nxt     = ST_CPU;
                    burst_cnt_nxt = '0;
                end else if (burst_cnt == BURST_LAST) begin
                    state_nxt     = ST_CPU;
                    burst_cnt_nxt = '0;
                    forced_nxt    = 1'b1;
                end else begin
                    burst_cnt_nxt = burst_cnt + BURST_ONE;
                end
            end
`ifdef MEM_ARBITER_IO_WAIT_EN
            ST_IOWAIT: begin
                if (wait_cnt == '0) state_nxt    = ST_CPU;
                else                wait_cnt_nxt = wait_cnt - WAIT_ONE;
            end
`endif
            default: state_nxt = ST_CPU;
        endcase
    end

    // Output logic
    always_comb begin
        cpu_ce      = 1'b0;
        cpu_in      = mem_rdata;
        dma_ack     = 1'b0;
        dma_rdata   = mem_rdata;
        mem_address = cpu_address;
        mem_wdata   = cpu_out;
        mem_we      = 1'b0;
        io_address  = cpu_address[15:0];
        io_wdata    = cpu_out;
        io_rd       = 1'b0;
        io_wr       = 1'b0;
        unique case (state)
            ST_CPU: begin
                if (strobe) begin
`ifndef MEM_ARBITER_IO_WAIT_EN
                    cpu_ce = 1'b1;
                    cpu_in = io_rdata;
                    io_rd  = cpu_pr;
                    io_wr  = cpu_pw;
`endif
                end else if (forced || !dma_req) begin
                    cpu_ce = 1'b1;
                    mem_we = cpu_we;
                end
            end
            ST_DMA: begin
                mem_address = dma_address;
                mem_wdata   = dma_wdata;
                if (dma_req) begin
                    dma_ack = 1'b1;
                    mem_we  = dma_we;
                end
            end
`ifdef MEM_ARBITER_IO_WAIT_EN
            ST_IOWAIT: begin
                io_address = io_address_q;
                io_wdata   = io_wdata_q;
                io_rd      = io_rd_q;
                io_wr      = io_wr_q;
                cpu_in     = io_rdata;
                cpu_ce     = (wait_cnt == '0);
            end
`endif
            default: ;
        endcase
        if (reset) begin
            cpu_ce  = 1'b0;
            dma_ack = 1'b0;
            mem_we  = 1'b0;
            io_rd   = 1'b0;
            io_wr   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized core/DMA traffic,
// checked each cycle against a transaction-level reference model.
// Follows MEM_ARBITER_IO_WAIT_EN the same way the design does.
module tb_mem_arbiter;

    localparam int BURST_MAX = 4;
    localparam int IO_WAIT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we, cpu_pr, cpu_pw;
    logic [7:0]  cpu_in;
    logic        cpu_ce;
    logic        dma_req;
    logic [19:0] dma_address;
    logic [7:0]  dma_wdata;
    logic        dma_we;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [19:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [15:0] io_address;
    logic [7:0]  io_wdata;
    logic        io_rd, io_wr;
    logic [7:0]  io_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.BURST_MAX(BURST_MAX), .IO_WAIT(IO_WAIT)) dut (
        .clock(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
        .cpu_pr(cpu_pr), .cpu_pw(cpu_pw), .cpu_in(cpu_in), .cpu_ce(cpu_ce),
        .dma_req(dma_req), .dma_address(dma_address), .dma_wdata(dma_wdata),
        .dma_we(dma_we), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .io_address(io_address), .io_wdata(io_wdata), .io_rd(io_rd), .io_wr(io_wr),
        .io_rdata(io_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: who owns the current cycle, in transaction terms.
    bit          m_in_burst = 0;   // a DMA burst is running
    int          m_done     = 0;   // transfers completed in this burst
    bit          m_owed     = 0;   // core is owed one cycle after a full burst
    int          m_io_left  = -1;  // remaining stall cycles of a port access, -1 = none
    logic [15:0] m_io_addr;
    logic [7:0]  m_io_wd;
    logic        m_io_pr, m_io_pw;

    // expectations of the cycle just checked, used by the traffic generators
    bit exp_ce, exp_ack;
    // observed values of the cycle just checked, used by directed scenarios
    logic       o_ce, o_ack, o_mwe, o_rd, o_wr;
    logic [7:0] o_in, o_mwdata;
    logic [19:0] o_maddr;
    logic [15:0] o_ioaddr;

    task automatic check_outputs();
        o_ce = cpu_ce; o_ack = dma_ack; o_mwe = mem_we; o_rd = io_rd; o_wr = io_wr;
        o_in = cpu_in; o_mwdata = mem_wdata; o_maddr = mem_address; o_ioaddr = io_address;
        exp_ce = 0; exp_ack = 0;
        if (reset) begin
            chk("rst_ce", cpu_ce, 0);
            chk("rst_ack", dma_ack, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_io_rd", io_rd, 0);
            chk("rst_io_wr", io_wr, 0);
        end else if (m_io_left >= 0) begin
            exp_ce = (m_io_left == 0);
            chk("io_ce", cpu_ce, exp_ce);
            chk("io_ack", dma_ack, 0);
            chk("io_mem_we", mem_we, 0);
            chk("io_rd", io_rd, m_io_pr);
            chk("io_wr", io_wr, m_io_pw);
            chk("io_address", io_address, m_io_addr);
            chk("io_wdata", io_wdata, m_io_wd);
            if (exp_ce) chk("io_cpu_in", cpu_in, io_rdata);
        end else if (m_in_burst) begin
            exp_ack = dma_req;
            chk("dma_ce", cpu_ce, 0);
            chk("dma_ack", dma_ack, exp_ack);
            chk("dma_mem_we", mem_we, dma_req & dma_we);
            chk("dma_io_rd", io_rd, 0);
            chk("dma_io_wr", io_wr, 0);
            if (dma_req) begin
                chk("dma_mem_addr", mem_address, dma_address);
                chk("dma_mem_wdata", mem_wdata, dma_wdata);
                chk("dma_rdata", dma_rdata, mem_rdata);
            end
        end else begin
            chk("cpu_ack", dma_ack, 0);
            if (cpu_pr | cpu_pw) begin
`ifdef MEM_ARBITER_IO_WAIT_EN
                exp_ce = 0;
                chk("port_start_ce", cpu_ce, 0);
                chk("port_start_rd", io_rd, 0);
                chk("port_start_wr", io_wr, 0);
`else
                exp_ce = 1;
                chk("port_ce", cpu_ce, 1);
                chk("port_rd", io_rd, cpu_pr);
                chk("port_wr", io_wr, cpu_pw);
                chk("port_address", io_address, cpu_address[15:0]);
                chk("port_cpu_in", cpu_in, io_rdata);
`endif
                chk("port_mem_we", mem_we, 0);
            end else begin
                exp_ce = m_owed || !dma_req;
                chk("cpu_ce", cpu_ce, exp_ce);
                chk("cpu_io_rd", io_rd, 0);
                chk("cpu_io_wr", io_wr, 0);
                chk("cpu_mem_we", mem_we, exp_ce ? cpu_we : 1'b0);
                if (exp_ce) begin
                    chk("cpu_mem_addr", mem_address, cpu_address);
                    chk("cpu_mem_wdata", mem_wdata, cpu_out);
                    chk("cpu_in", cpu_in, mem_rdata);
                end
            end
        end
    endtask

    task automatic model_advance();
        if (reset) begin
            m_in_burst = 0; m_done = 0; m_owed = 0; m_io_left = -1;
        end else if (m_io_left >= 0) begin
            m_io_left--;
        end else if (m_in_burst) begin
            if (!dma_req) begin
                m_in_burst = 0; m_done = 0;
            end else begin
                m_done++;
                if (m_done == BURST_MAX) begin
                    m_in_burst = 0; m_done = 0; m_owed = 1;
                end
            end
        end else if (cpu_pr | cpu_pw) begin
            m_owed = 0;
`ifdef MEM_ARBITER_IO_WAIT_EN
            m_io_left = IO_WAIT;
            m_io_addr = cpu_address[15:0];
            m_io_wd   = cpu_out;
            m_io_pr   = cpu_pr;
            m_io_pw   = cpu_pw;
`endif
        end else if (m_owed) begin
            m_owed = 0;
            m_in_burst = dma_req;
        end else if (dma_req) begin
            m_in_burst = 1;
        end
    endtask

    // Called just after a rising edge with inputs already set.
    task automatic run_cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        reset = 1; run_cycle(); reset = 0;
    endtask

    task automatic gen_random();
        logic [31:0] r1, r2;
        r1 = $urandom; r2 = $urandom;
        mem_rdata = r1[7:0];
        io_rdata  = r1[15:8];
        if (reset) reset = r1[16];
        else       reset = ($urandom_range(0, 79) == 0);
        if (exp_ce) begin
            cpu_address = r2[19:0];
            cpu_out     = r2[27:20];
            cpu_we      = r2[28];
            cpu_pr      = 0;
            cpu_pw      = 0;
            case ($urandom_range(0, 9))
                0: begin cpu_pr = 1; cpu_we = 0; end
                1: begin cpu_pw = 1; cpu_we = 0; end
                default: ;
            endcase
        end
        r2 = $urandom;
        if ((dma_req && exp_ack) || !dma_req) begin
            dma_req     = dma_req ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            dma_address = r2[19:0];
            dma_wdata   = r2[27:20];
            dma_we      = r2[28];
        end
    endtask

    int ack_seq[11];
    int ce_seq[11];

    initial begin
        reset = 1; cpu_address = '0; cpu_out = '0; cpu_we = 0; cpu_pr = 0; cpu_pw = 0;
        dma_req = 0; dma_address = '0; dma_wdata = '0; dma_we = 0;
        mem_rdata = '0; io_rdata = '0;
        repeat (2) run_cycle();
        chk("reset_hold_ce", o_ce, 0);
        reset = 0;

        // idle core read
        cpu_address = 20'h12345; mem_rdata = 8'hA5;
        run_cycle();
        chk("idle_ce", o_ce, 1);
        chk("idle_mem_addr", o_maddr, 20'h12345);
        chk("idle_cpu_in", o_in, 8'hA5);

        // single DMA write
        dma_req = 1; dma_we = 1; dma_address = 20'hB8000; dma_wdata = 8'h41;
        run_cycle();
        chk("dmaw_grant_ce", o_ce, 0);
        chk("dmaw_grant_ack", o_ack, 0);
        run_cycle();
        chk("dmaw_mem_we", o_mwe, 1);
        chk("dmaw_mem_addr", o_maddr, 20'hB8000);
        chk("dmaw_mem_wdata", o_mwdata, 8'h41);
        chk("dmaw_ack", o_ack, 1);
        chk("dmaw_ce", o_ce, 0);
        dma_req = 0; dma_we = 0;
        repeat (2) run_cycle();

        // held request: 4 transfers, one core cycle, repeated
        do_reset();
        dma_req = 1;
        for (int i = 0; i < 11; i++) begin
            run_cycle();
            ack_seq[i] = o_ack; ce_seq[i] = o_ce;
        end
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("burst_ack[%0d]", i), ack_seq[i], (i >= 1 && i <= 4) || (i >= 6 && i <= 9));
            chk($sformatf("burst_ce[%0d]", i), ce_seq[i], (i == 5 || i == 10));
        end
        dma_req = 0;
        repeat (2) run_cycle();

        // port read
        do_reset();
        cpu_pr = 1; cpu_address = 20'h003F8; io_rdata = 8'h5C;
`ifdef MEM_ARBITER_IO_WAIT_EN
        run_cycle();
        chk("pr_start_ce", o_ce, 0);
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            chk($sformatf("pr_ce[%0d]", i), o_ce, (i == 2));
            chk($sformatf("pr_io_rd[%0d]", i), o_rd, 1);
            chk($sformatf("pr_io_addr[%0d]", i), o_ioaddr, 16'h03F8);
        end
        chk("pr_cpu_in", o_in, 8'h5C);
`else
        run_cycle();
        chk("pr_ce", o_ce, 1);
        chk("pr_io_rd", o_rd, 1);
        chk("pr_io_addr", o_ioaddr, 16'h03F8);
        chk("pr_cpu_in", o_in, 8'h5C);
`endif
        cpu_pr = 0;
        run_cycle();
        chk("pr_after_rd", o_rd, 0);

        // port write racing a DMA request
        do_reset();
        cpu_pw = 1; dma_req = 1; cpu_out = 8'h77;
`ifdef MEM_ARBITER_IO_WAIT_EN
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            ack_seq[i] = o_ack; ce_seq[i] = o_ce;
            if (i == 1) chk("pw_io_wr", o_wr, 1);
            if (i == 3) cpu_pw = 0;
        end
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("pw_ack[%0d]", i), ack_seq[i], (i == 5));
            chk($sformatf("pw_ce[%0d]", i), ce_seq[i], (i == 3));
        end
`else
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            ack_seq[i] = o_ack; ce_seq[i] = o_ce;
            if (i == 0) begin
                chk("pw_io_wr", o_wr, 1);
                cpu_pw = 0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pw_ack[%0d]", i), ack_seq[i], (i == 2));
            chk($sformatf("pw_ce[%0d]", i), ce_seq[i], (i == 0));
        end
`endif
        dma_req = 0;
        repeat (2) run_cycle();

        // reset in the middle of a burst
        do_reset();
        dma_req = 1;
        repeat (2) run_cycle();
        chk("rb_first_ack", o_ack, 1);
        reset = 1;
        run_cycle();
        chk("rb_rst_ack", o_ack, 0);
        chk("rb_rst_ce", o_ce, 0);
        reset = 0;
        run_cycle();
        chk("rb_rel_ack", o_ack, 0);
        chk("rb_rel_ce", o_ce, 0);
        run_cycle();
        chk("rb_resume_ack", o_ack, 1);
        dma_req = 0;
        run_cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            gen_random();
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
